rst_seq: RTL and testbench
==========================

# rst_seq

Reset release sequencer that sits directly downstream of the reset synchronizer. It takes the already-synchronized system reset and holds a set of domain resets asserted for a minimum time. It then releases them one by one in a fixed order, with a programmable gap between releases. It also re-enters the reset sequence on software or watchdog requests and records the cause of the last reset.

## Interface
- NUM_DOM, 4, number of sequenced reset domains (≥1); domain 0 is released first.
- HOLD_CYC, 16, minimum assertion time in clk_i cycles before the first release (≥1).
- GAP_W, 8, width of the inter-domain gap input.
- clk_i  in  1  sole clock.
- rst_n_i  in  1  reset, asynchronous and active-low; driven by the synchronizer output, so deassertion is already clock-aligned.
- sw_rst_req_i  in  1  software reset request; level sampled each cycle.
- wdt_rst_req_i  in  1  watchdog reset request; level sampled each cycle.
- gap_i  in  GAP_W  extra cycles between consecutive domain releases; sampled once, on the ASSERT→RELEASE edge.
- rst_n_o  out  NUM_DOM  per-domain active-low resets.
- busy_o  out  1  high while in ASSERT or RELEASE.
- done_o  out  1  one-cycle pulse when the sequence completes.
- cause_o  out  2  last reset cause: 0 = POR, 1 = SW, 2 = WDT, 3 = reserved (never driven).

## Operation
- States:
  - ASSERT: all rst_n_o low; the hold counter runs.
  - RELEASE: domains are released in index order.
  - RUN: all rst_n_o high.
- The reset value of every register is applied asynchronously while rst_n_i is low: state ASSERT, counter 0, domain index 0, rst_n_o all 0, busy_o 1, done_o 0, cause_o POR.
- ASSERT:
  - The counter increments every edge.
  - On the edge where counter == HOLD_CYC-1: rst_n_o[0] goes 1, gap_i is latched, the counter clears, the domain index becomes 1, and the state becomes RELEASE (or RUN if NUM_DOM == 1).
- RELEASE:
  - The counter increments every edge.
  - On the edge where counter == latched gap: rst_n_o[index] goes 1, the index increments and the counter clears.
  - Releasing domain NUM_DOM-1 moves the state to RUN.
- RUN entry: done_o goes high on the same edge as the final release, for exactly one cycle; busy_o goes 0 on that edge.
- Request in RUN:
  - On the next edge, all rst_n_o go 0, the state becomes ASSERT, the counter and index clear, and cause_o updates.
  - The full HOLD_CYC hold applies again.
- Request in RELEASE: the sequence aborts with the same action as in RUN (all domains go low again and cause_o updates).
- Request in ASSERT: ignored. The counter does not restart and cause_o does not change.
- Simultaneous sw and wdt requests: WDT wins, cause_o = 2.
- A request held high for several cycles acts as one request per entry into RUN or RELEASE. It re-triggers only after the sequence has left ASSERT.
- rst_n_i low at any time: immediate asynchronous return to the reset values, and cause_o returns to POR.

## Timing
- Edges are numbered from 1, starting at the first rising clk_i edge after rst_n_i deasserts.
- Domain k rises on edge HOLD_CYC + k·(G+1), where G is the latched gap. Example: HOLD_CYC = 16, G = 3 gives edges 16, 20, 24, 28.
- G = 0 releases the domains on consecutive edges.
- A request sampled high at edge E produces rst_n_o all 0 after edge E. Domain 0 rises again at edge E + HOLD_CYC.
- All outputs are driven directly from flops; there is no combinational path from input to output.
- Counter width is max($clog2(HOLD_CYC), GAP_W). gap_i = 2^GAP_W−1 must not overflow the counter.

## Structure
- Shared package rst_pkg holds:
  - the state enum: ASSERT, RELEASE, RUN;
  - the cause enum and its encodings: POR = 2'd0, SW = 2'd1, WDT = 2'd2.
- Single module with no sub-module. The hold/gap counter and the domain index are shared between states.

## Test plan
- Power-on with defaults and gap_i = 3, rst_n_i rising before edge 1 → rst_n_o goes 0001 at edge 16, 0011 at 20, 0111 at 24, 1111 at 28. done_o is high for one cycle after edge 28, cause_o = 0.
- gap_i = 0 → domains release on edges 16, 17, 18, 19. Changing gap_i to 7 at edge 17 has no effect.
- sw_rst_req_i pulse at edge 40 in RUN → rst_n_o = 0000 after edge 40, cause_o = 1, domain 0 rises at edge 56.
- sw and wdt requests high together at edge 40 → cause_o = 2. A further wdt pulse during ASSERT at edge 45 → ignored, domain 0 still rises at edge 56.
- wdt pulse at edge 22, during RELEASE with 0011 out → 0000 after edge 22, cause_o = 2, full sequence restarts.
- rst_n_i pulled low mid-RELEASE, between clock edges → rst_n_o = 0000 immediately (asynchronously), cause_o = 0, busy_o = 1, done_o = 0.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared types for the reset release sequencer: sequencer states and
// the encoding of the recorded reset cause.
package rst_pkg;

    // Sequencer phases: hold everything in reset, release domains one
    // at a time, then run with all domains out of reset.
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    // Cause of the most recent reset. Encoding 2'd3 is reserved and is
    // never produced by the sequencer.
    typedef enum logic [1:0] {
        POR = 2'd0,
        SW  = 2'd1,
        WDT = 2'd2
    } cause_t;

    // Width needed to hold the larger of the hold count and the gap.
    function automatic int cnt_width(input int hold_cyc, input int gap_w);
        int hold_w;
        hold_w = $clog2(hold_cyc);
        return (hold_w > gap_w) ? hold_w : gap_w;
    endfunction

endpackage

// File: rtl/rst_seq.sv
// Reset release sequencer. Sits behind the reset synchronizer, holds all
// domain resets for a minimum time, then releases the domains in index
// order with a programmable gap. Software and watchdog requests restart
// the sequence, and the cause of the last reset is kept for software.
module rst_seq
    import rst_pkg::*;
#(
    parameter int NUM_DOM  = 4,
    parameter int HOLD_CYC = 16,
    parameter int GAP_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               sw_rst_req_i,
    input  logic               wdt_rst_req_i,
    input  logic [GAP_W-1:0]   gap_i,
    output logic [NUM_DOM-1:0] rst_n_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         cause_o
);

    // One shared counter serves both the initial hold and the gaps, so it
    // must be wide enough for either; an all-ones gap must still fit.
    localparam int CNT_W = cnt_width(HOLD_CYC, GAP_W);
    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOM - 1);

    state_t             state;
    cause_t             cause_q;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [GAP_W-1:0]   gap_q;
    logic [CNT_W-1:0]   gap_ext;
    logic               req;
    cause_t             req_cause;

    // Merge the two request sources; the watchdog wins when both are high.
    always_comb begin
        req       = sw_rst_req_i | wdt_rst_req_i;
        req_cause = wdt_rst_req_i ? WDT : SW;
        gap_ext   = CNT_W'(gap_q);
    end

    // Sequencer: every output is a flop so no input reaches an output
    // combinationally. Requests are levels; a held request simply fires
    // again each time the sequence leaves ASSERT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            gap_q   <= '0;
            rst_n_o <= '0;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            cause_q <= POR;
        end else begin
            done_o <= 1'b0;
            case (state)
                ASSERT: begin
                    if (cnt == HOLD_LAST) begin
                        rst_n_o[0] <= 1'b1;
                        gap_q      <= gap_i;
                        cnt        <= '0;
                        if (NUM_DOM == 1) begin
                            idx    <= '0;
                            state  <= RUN;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            idx   <= IDX_W'(1);
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    if (req) begin
                        rst_n_o <= '0;
                        state   <= ASSERT;
                        cnt     <= '0;
                        idx     <= '0;
                        busy_o  <= 1'b1;
                        cause_q <= req_cause;
                    end else if (cnt == gap_ext) begin
                        for (int d = 0; d < NUM_DOM; d++) begin
                            if (IDX_W'(d) == idx) begin
                                rst_n_o[d] <= 1'b1;
                            end
                        end
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            idx    <= '0;
                            state  <= RUN;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RUN: begin
                    if (req) begin
                        rst_n_o <= '0;
                        state   <= ASSERT;
                        cnt     <= '0;
                        idx     <= '0;
                        busy_o  <= 1'b1;
                        cause_q <= req_cause;
                    end
                end

                default: begin
                    rst_n_o <= '0;
                    state   <= ASSERT;
                    cnt     <= '0;
                    idx     <= '0;
                    busy_o  <= 1'b1;
                end
            endcase
        end
    end

    assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed testbench for the reset release sequencer: release timing,
// gap latching, request handling and asynchronous reset.
module tb_rst_seq;

    logic       clock;
    logic       rstN;
    logic       swReq;
    logic       wdtReq;
    logic [7:0] gap;
    logic [3:0] domRstN;
    logic       busy;
    logic       done;
    logic [1:0] cause;

    int checkCount = 0;
    int failCount  = 0;
    int edgeCnt;

    rst_seq #(.NUM_DOM(4), .HOLD_CYC(16), .GAP_W(8)) dut (
        .clk_i         (clock),
        .rst_n_i       (rstN),
        .sw_rst_req_i  (swReq),
        .wdt_rst_req_i (wdtReq),
        .gap_i         (gap),
        .rst_n_o       (domRstN),
        .busy_o        (busy),
        .done_o        (done),
        .cause_o       (cause)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Edge numbering: edge 1 is the first rising edge after reset release
    always @(posedge clock or negedge rstN) begin
        if (!rstN) edgeCnt <= 0;
        else       edgeCnt <= edgeCnt + 1;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to the falling edge following rising edge number e
    task automatic stepTo(input int e);
        while (edgeCnt < e) @(negedge clock);
    endtask

    // Assert reset, check the reset values, and release on a falling edge
    task automatic applyStimulus(input logic [7:0] newGap);
        @(negedge clock);
        rstN   = 1'b0;
        swReq  = 1'b0;
        wdtReq = 1'b0;
        gap    = newGap;
        @(negedge clock);
        checkOutput("rst_domains", 32'(domRstN), 32'h0);
        checkOutput("rst_busy",    32'(busy),    32'h1);
        checkOutput("rst_done",    32'(done),    32'h0);
        checkOutput("rst_cause",   32'(cause),   32'h0);
        rstN = 1'b1;
    endtask

    initial begin
        rstN   = 1'b0;
        swReq  = 1'b0;
        wdtReq = 1'b0;
        gap    = 8'd0;

        // Power-on, gap 3: releases at 16, 20, 24, 28
        applyStimulus(8'd3);
        stepTo(15); checkOutput("g3_e15", 32'(domRstN), 32'h0);
        stepTo(16); checkOutput("g3_e16", 32'(domRstN), 32'h1);
        checkOutput("g3_busy16", 32'(busy), 32'h1);
        stepTo(19); checkOutput("g3_e19", 32'(domRstN), 32'h1);
        stepTo(20); checkOutput("g3_e20", 32'(domRstN), 32'h3);
        stepTo(24); checkOutput("g3_e24", 32'(domRstN), 32'h7);
        stepTo(27); checkOutput("g3_done27", 32'(done), 32'h0);
        checkOutput("g3_e27", 32'(domRstN), 32'h7);
        stepTo(28); checkOutput("g3_e28", 32'(domRstN), 32'hF);
        checkOutput("g3_done28", 32'(done),  32'h1);
        checkOutput("g3_busy28", 32'(busy),  32'h0);
        checkOutput("g3_cause",  32'(cause), 32'h0);
        stepTo(29); checkOutput("g3_done29", 32'(done), 32'h0);

        // Gap 0: consecutive releases; gap change after latching is ignored
        applyStimulus(8'd0);
        stepTo(16); checkOutput("g0_e16", 32'(domRstN), 32'h1);
        gap = 8'd7;
        stepTo(17); checkOutput("g0_e17", 32'(domRstN), 32'h3);
        stepTo(18); checkOutput("g0_e18", 32'(domRstN), 32'h7);
        stepTo(19); checkOutput("g0_e19", 32'(domRstN), 32'hF);
        checkOutput("g0_done19", 32'(done), 32'h1);

        // Software request in RUN at edge 40; new gap 7 latched at edge 56
        stepTo(39); swReq = 1'b1;
        stepTo(40); swReq = 1'b0;
        checkOutput("sw_e40",    32'(domRstN), 32'h0);
        checkOutput("sw_cause",  32'(cause),   32'h1);
        checkOutput("sw_busy",   32'(busy),    32'h1);
        stepTo(55); checkOutput("sw_e55", 32'(domRstN), 32'h0);
        stepTo(56); checkOutput("sw_e56", 32'(domRstN), 32'h1);
        stepTo(63); checkOutput("sw_e63", 32'(domRstN), 32'h1);
        stepTo(64); checkOutput("sw_e64", 32'(domRstN), 32'h3);

        // Simultaneous requests: watchdog wins; request in ASSERT ignored
        applyStimulus(8'd3);
        stepTo(39); swReq = 1'b1; wdtReq = 1'b1;
        stepTo(40); swReq = 1'b0; wdtReq = 1'b0;
        checkOutput("both_e40",   32'(domRstN), 32'h0);
        checkOutput("both_cause", 32'(cause),   32'h2);
        stepTo(44); wdtReq = 1'b1;
        stepTo(45); wdtReq = 1'b0;
        checkOutput("asrt_cause", 32'(cause), 32'h2);
        stepTo(55); checkOutput("asrt_e55", 32'(domRstN), 32'h0);
        stepTo(56); checkOutput("asrt_e56", 32'(domRstN), 32'h1);

        // Watchdog during RELEASE at edge 22 restarts the whole sequence
        applyStimulus(8'd3);
        stepTo(21); checkOutput("rel_e21", 32'(domRstN), 32'h3);
        wdtReq = 1'b1;
        stepTo(22); wdtReq = 1'b0;
        checkOutput("rel_e22",   32'(domRstN), 32'h0);
        checkOutput("rel_cause", 32'(cause),   32'h2);
        checkOutput("rel_busy",  32'(busy),    32'h1);
        stepTo(37); checkOutput("rel_e37", 32'(domRstN), 32'h0);
        stepTo(38); checkOutput("rel_e38", 32'(domRstN), 32'h1);
        stepTo(42); checkOutput("rel_e42", 32'(domRstN), 32'h3);

        // Asynchronous reset between clock edges while mid-RELEASE
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_domains", 32'(domRstN), 32'h0);
        checkOutput("async_cause",   32'(cause),   32'h0);
        checkOutput("async_busy",    32'(busy),    32'h1);
        checkOutput("async_done",    32'(done),    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
